// File: rtl/iq_integrate_dump.sv
// Integrate-and-dump correlator for one I/Q pair: code wipe-off, saturating accumulation
// over a programmable number of samples, and a valid/ready result port with sticky status flags.
module iq_integrate_dump #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 18
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic signed [IN_W-1:0]  s_i_data,
  input  logic signed [IN_W-1:0]  s_q_data,
  input  logic                    s_valid,
  input  logic                    code_chip,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        dump_len,
  output logic signed [ACC_W-1:0] m_i_acc,
  output logic signed [ACC_W-1:0] m_q_acc,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    overrun,
  output logic                    sat
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [IN_W-1:0]  IN_MIN  = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0]  IN_MAX  = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] LEN_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The most negative sample has no positive twin, so its negation clamps to the maximum.
  function automatic logic [IN_W-1:0] applyChip(input logic [IN_W-1:0] x, input logic neg);
    if (!neg)
      return x;
    else if (x == IN_MIN)
      return IN_MAX;
    else
      return -x;
  endfunction

  // Returns {clamped, value}: one guard bit detects overflow of the signed add.
  function automatic logic [ACC_W:0] satAdd(input logic [ACC_W-1:0] acc, input logic [IN_W-1:0] prod);
    logic [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){prod[IN_W-1]}}, prod};
    if (sum[ACC_W] != sum[ACC_W-1])
      return {1'b1, (sum[ACC_W] ? ACC_MIN : ACC_MAX)};
    else
      return {1'b0, sum[ACC_W-1:0]};
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             p1Valid_q;
  logic [IN_W-1:0]  p1I_q;
  logic [IN_W-1:0]  p1Q_q;
  logic [IN_W-1:0]  p1I_d;
  logic [IN_W-1:0]  p1Q_d;
  logic [ACC_W-1:0] accI_q;
  logic [ACC_W-1:0] accQ_q;
  logic [ACC_W-1:0] accI_d;
  logic [ACC_W-1:0] accQ_d;
  logic [ACC_W-1:0] outI_q;
  logic [ACC_W-1:0] outQ_q;
  logic             mValid_q;
  logic             overrun_q;
  logic             sat_q;

  logic             clampI;
  logic             clampQ;
  logic             accept;
  logic             accumStep;
  logic             lastSample;
  logic [CNT_W-1:0] lenLatch;

  always_comb begin
    accept         = (state_q == ACCUM) && enable && s_valid;
    accumStep      = (state_q == ACCUM) && enable && p1Valid_q;
    p1I_d          = applyChip(s_i_data, code_chip);
    p1Q_d          = applyChip(s_q_data, code_chip);
    {clampI, accI_d} = satAdd(accI_q, p1I_q);
    {clampQ, accQ_d} = satAdd(accQ_q, p1Q_q);
    cnt_d          = cnt_q + 1'b1;
    lastSample     = accumStep && (cnt_d == len_q);
    lenLatch       = (dump_len == '0) ? LEN_ONE : dump_len;
  end

  // Control, pipeline and result registers. Dropping enable throws away the partial period
  // but leaves any unread result in place until it is handshaken.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      p1Valid_q <= 1'b0;
      p1I_q     <= '0;
      p1Q_q     <= '0;
      accI_q    <= '0;
      accQ_q    <= '0;
      outI_q    <= '0;
      outQ_q    <= '0;
      mValid_q  <= 1'b0;
      overrun_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      if (!enable) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        p1Valid_q <= 1'b0;
        p1I_q     <= '0;
        p1Q_q     <= '0;
        accI_q    <= '0;
        accQ_q    <= '0;
      end else if (state_q == IDLE) begin
        state_q <= ACCUM;
        len_q   <= lenLatch;
      end else begin
        p1Valid_q <= accept;
        if (accept) begin
          p1I_q <= p1I_d;
          p1Q_q <= p1Q_d;
        end
        if (lastSample) begin
          outI_q <= accI_d;
          outQ_q <= accQ_d;
          accI_q <= '0;
          accQ_q <= '0;
          cnt_q  <= '0;
          len_q  <= lenLatch;
        end else if (accumStep) begin
          accI_q <= accI_d;
          accQ_q <= accQ_d;
          cnt_q  <= cnt_d;
        end
      end

      if (accumStep && (clampI || clampQ))
        sat_q <= 1'b1;

      // A new dump keeps m_valid high; an unread result being replaced marks an overrun.
      if (lastSample) begin
        mValid_q <= 1'b1;
        if (mValid_q && !m_ready)
          overrun_q <= 1'b1;
      end else if (mValid_q && m_ready) begin
        mValid_q <= 1'b0;
      end
    end
  end

  assign m_i_acc = outI_q;
  assign m_q_acc = outQ_q;
  assign m_valid = mValid_q;
  assign overrun = overrun_q;
  assign sat     = sat_q;

endmodule
